// File: rtl/prim_esc_pkg.sv
// Shared state encoding and constants for the escalation receiver.
// The optional ping-timeout counter is enabled with PRIM_ESC_RX_TIMEOUT_EN.
package prim_esc_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StCheck    = 3'b001,
        StPingResp = 3'b010,
        StPingEnd  = 3'b011,
        StEscResp  = 3'b100,
        StSigInt   = 3'b101
    } esc_state_e;

    // {resp_p, resp_n} driven while nothing is in flight
    localparam logic [1:0] IdleResp = 2'b01;

    localparam int unsigned TimeoutMinCycles = 4;
    localparam int unsigned TimeoutMaxCycles = 65536;

    function automatic logic is_esc_state(input esc_state_e st);
        return (st == StEscResp) || (st == StSigInt);
    endfunction

endpackage

// File: rtl/prim_diff_decode.sv
// Differential pair decoder: asserted level and signal-integrity indication.
module prim_diff_decode (
    input  logic diff_p_i,
    input  logic diff_n_i,
    output logic level_o,
    output logic sigint_o
);

    assign sigint_o = (diff_p_i == diff_n_i);
    assign level_o  = diff_p_i;

endmodule

// File: rtl/prim_esc_receiver.sv
// Escalation receiver: answers pings, forwards escalation, flags pair integrity.
// Define PRIM_ESC_RX_TIMEOUT_EN to compile in the ping-timeout counter.
module prim_esc_receiver
    import prim_esc_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic esc_p_i,
    input  logic esc_n_i,
    output logic resp_p_o,
    output logic resp_n_o,
    output logic esc_en_o,
    output logic sigint_o,
    output logic timeout_o
);

    if (TimeoutCycles < TimeoutMinCycles || TimeoutCycles > TimeoutMaxCycles) begin : gen_bad_cfg
        $error("prim_esc_receiver: TimeoutCycles out of range 4..65536");
    end

    logic       esc_level;
    logic       esc_sigint;
    esc_state_e state_d, state_q;
    logic       resp_p_d, resp_p_q;
    logic       resp_n_d, resp_n_q;
    logic       esc_en_d, esc_en_q;
    logic       sigint_d, sigint_q;
    logic       timeout_d, timeout_q;

    prim_diff_decode u_diff_decode (
        .diff_p_i (esc_p_i),
        .diff_n_i (esc_n_i),
        .level_o  (esc_level),
        .sigint_o (esc_sigint)
    );

    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin : p_next_state
        state_d = state_q;
        if (esc_sigint) begin
            state_d = StSigInt;
        end else begin
            case (state_q)
                StIdle:     state_d = esc_level ? StCheck   : StIdle;
                StCheck:    state_d = esc_level ? StEscResp : StPingResp;
                StPingResp: state_d = esc_level ? StCheck   : StPingEnd;
                StPingEnd:  state_d = esc_level ? StCheck   : StIdle;
                StEscResp:  state_d = esc_level ? StEscResp : StIdle;
                StSigInt:   state_d = esc_level ? StCheck   : StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    always_comb begin : p_outputs
        {resp_p_d, resp_n_d} = IdleResp;
        case (state_d)
            StCheck, StPingEnd: {resp_p_d, resp_n_d} = 2'b10;
            StEscResp:          {resp_p_d, resp_n_d} = {~resp_p_q, ~resp_n_q};
            StSigInt: begin
                // both rails toggle together so the sender sees the pair as broken
                resp_p_d = (state_q == StSigInt) ? ~resp_p_q : 1'b1;
                resp_n_d = resp_p_d;
            end
            default: ;
        endcase
        sigint_d = (state_d == StSigInt);
        esc_en_d = is_esc_state(state_d) | timeout_d;
    end

`ifdef PRIM_ESC_RX_TIMEOUT_EN
    localparam int unsigned    CntW   = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            cnt_sat;

    always_comb begin : p_timeout
        cnt_sat   = (cnt_q == CntMax);
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_d inside {StCheck, StPingEnd, StEscResp, StSigInt}) begin
            cnt_d = '0;
        end else if (state_q == StIdle && !cnt_sat) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_d == StPingEnd) begin
            timeout_d = 1'b0;
        end else if (state_q == StIdle && cnt_sat) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin : p_cnt_reg
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_d = 1'b0;
`endif

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin : p_state_reg
        if (rst_i) begin
            state_q              <= StIdle;
            {resp_p_q, resp_n_q} <= IdleResp;
            esc_en_q             <= 1'b0;
            sigint_q             <= 1'b0;
            timeout_q            <= 1'b0;
        end else begin
            state_q   <= state_d;
            resp_p_q  <= resp_p_d;
            resp_n_q  <= resp_n_d;
            esc_en_q  <= esc_en_d;
            sigint_q  <= sigint_d;
            timeout_q <= timeout_d;
        end
    end

    assign resp_p_o  = resp_p_q;
    assign resp_n_o  = resp_n_q;
    assign esc_en_o  = esc_en_q;
    assign sigint_o  = sigint_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_prim_esc_receiver.sv
// Directed bench for prim_esc_receiver; outputs compared as {resp_p, resp_n, esc_en, sigint, timeout}.
module tb_prim_esc_receiver;

    logic clk_i = 1'b0;
    logic rst_i;
    logic esc_p_i;
    logic esc_n_i;
    logic resp_p_o;
    logic resp_n_o;
    logic esc_en_o;
    logic sigint_o;
    logic timeout_o;

    prim_esc_receiver #(
        .TimeoutCycles (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .esc_p_i   (esc_p_i),
        .esc_n_i   (esc_n_i),
        .resp_p_o  (resp_p_o),
        .resp_n_o  (resp_n_o),
        .esc_en_o  (esc_en_o),
        .sigint_o  (sigint_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [4:0] O_IDLE  = 5'b01000;
    localparam logic [4:0] O_HI    = 5'b10000;
    localparam logic [4:0] O_ESC_L = 5'b01100;
    localparam logic [4:0] O_ESC_H = 5'b10100;
    localparam logic [4:0] O_SI_H  = 5'b11110;
    localparam logic [4:0] O_SI_L  = 5'b00110;
    localparam logic [4:0] O_TO    = 5'b01101;

    typedef struct {
        logic       rst;
        logic       esc_p;
        logic       esc_n;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic p, input logic n,
                       input logic [4:0] exp, input string name);
        vec_t v;
        v.rst   = rst;
        v.esc_p = p;
        v.esc_n = n;
        v.exp   = exp;
        v.name  = name;
        vecs.push_back(v);
    endtask

    task automatic step(input logic rst, input logic p, input logic n);
        rst_i   = rst;
        esc_p_i = p;
        esc_n_i = n;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {resp_p_o, resp_n_o, esc_en_o, sigint_o, timeout_o};
    endfunction

    initial begin
        logic seen;

        rst_i   = 1'b1;
        esc_p_i = 1'b0;
        esc_n_i = 1'b1;

        add(1, 0, 1, O_IDLE,  "reset");
        add(0, 0, 1, O_IDLE,  "idle");
        add(0, 1, 0, O_HI,    "ping_check");
        add(0, 0, 1, O_IDLE,  "ping_resp");
        add(0, 0, 1, O_HI,    "ping_end");
        add(0, 0, 1, O_IDLE,  "ping_idle");
        add(0, 0, 1, O_IDLE,  "ping_idle2");
        add(0, 1, 0, O_HI,    "esc_check");
        for (int i = 0; i < 9; i++)
            add(0, 1, 0, (i % 2 == 0) ? O_ESC_L : O_ESC_H, $sformatf("esc_hold_%0d", i));
        add(0, 0, 1, O_IDLE,  "esc_release");
        add(0, 1, 1, O_SI_H,  "sigint_1");
        add(0, 1, 1, O_SI_L,  "sigint_2");
        add(0, 1, 1, O_SI_H,  "sigint_3");
        add(0, 0, 1, O_IDLE,  "sigint_exit");
        add(0, 0, 0, O_SI_H,  "sigint_00");
        add(0, 1, 0, O_HI,    "sigint_to_check");
        add(0, 0, 1, O_IDLE,  "check_to_ping");
        add(0, 1, 0, O_HI,    "pingresp_override");
        add(0, 0, 1, O_IDLE,  "ping_resp_b");
        add(0, 0, 1, O_HI,    "ping_end_b");
        add(0, 1, 0, O_HI,    "pingend_override");
        add(0, 1, 0, O_ESC_L, "esc_after_override");
        add(0, 1, 1, O_SI_H,  "esc_to_sigint");
        add(0, 1, 0, O_HI,    "sigint_to_check_b");
        add(0, 0, 0, O_SI_H,  "check_to_sigint");
        add(0, 0, 1, O_IDLE,  "sigint_exit_b");
        add(0, 1, 0, O_HI,    "rst_esc_check");
        add(0, 1, 0, O_ESC_L, "rst_esc_1");
        add(0, 1, 0, O_ESC_H, "rst_esc_2");
        add(0, 1, 0, O_ESC_L, "rst_esc_3");
        add(1, 1, 0, O_IDLE,  "rst_mid_esc");
        add(0, 0, 1, O_IDLE,  "rst_esc_no_resume");
        add(0, 1, 0, O_HI,    "rst_ping_check");
        add(1, 0, 1, O_IDLE,  "rst_mid_ping");
        add(0, 0, 1, O_IDLE,  "rst_ping_idle_1");
        add(0, 0, 1, O_IDLE,  "rst_ping_idle_2");
        add(1, 1, 1, O_IDLE,  "rst_over_invalid");
        add(0, 1, 1, O_SI_H,  "invalid_after_rst");
        add(0, 0, 1, O_IDLE,  "invalid_after_rst_exit");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].esc_p, vecs[i].esc_n);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

`ifdef PRIM_ESC_RX_TIMEOUT_EN
        step(1, 0, 1);
        check("to_reset", outs(), O_IDLE);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1);
            check($sformatf("to_count_%0d", i), outs(), O_IDLE);
        end
        step(0, 0, 1);
        check("to_fire", outs(), O_TO);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            check($sformatf("to_sticky_%0d", i), outs(), O_TO);
        end
        step(0, 1, 0);
        check("to_ping_check", outs(), 5'b10101);
        step(0, 0, 1);
        check("to_ping_resp", outs(), O_TO);
        step(0, 0, 1);
        check("to_ping_end_clears", outs(), O_HI);
        step(0, 0, 1);
        check("to_ping_idle", outs(), O_IDLE);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        check("to_refire", outs(), O_TO);
        step(1, 0, 1);
        check("to_reset_clears", outs(), O_IDLE);
`else
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(0, 0, 1);
            seen |= timeout_o | esc_en_o;
        end
        check("no_timeout_1000", {4'b0, seen}, 5'b0);
        check("idle_after_1000", outs(), O_IDLE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prim_esc_receiver.md
PRIM_ESC_RECEIVER -- requirements
Module: prim_esc_receiver

Interface
REQ-001 Parameter TimeoutCycles, default 256, number of Idle cycles without a completed ping before the receiver self-escalates; legal range 4..65536.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous reset, active-high, sampled on clk_i.
REQ-004 esc_p_i  input  1  escalation differential pair, positive rail.
REQ-005 esc_n_i  input  1  escalation differential pair, negative rail.
REQ-006 resp_p_o  output  1  response differential pair, positive rail, registered.
REQ-007 resp_n_o  output  1  response differential pair, negative rail, registered.
REQ-008 esc_en_o  output  1  escalation action enable to the local consumer, registered.
REQ-009 sigint_o  output  1  signal-integrity failure flag, registered.
REQ-010 timeout_o  output  1  ping timeout flag, registered.

Function
REQ-011 The pair is valid when esc_p_i != esc_n_i; the asserted level is esc_p_i.
REQ-012 States: Idle, Check, PingResp, PingEnd, EscResp, SigInt; all outputs are registered from next-state logic, so every output reflects the state entered, one cycle after the input sample.
REQ-013 Idle: resp=(0,1); valid level 1 -> Check with resp=(1,0); valid level 0 -> stay Idle.
REQ-014 Check: valid level 1 -> EscResp with esc_en_o=1, resp=(0,1); valid level 0 -> PingResp with resp=(0,1).
REQ-015 PingResp: resp=(1,0) next, -> PingEnd; PingEnd -> Idle with resp=(0,1); ping response on resp_p_o is therefore 1,0,1,0 over four cycles.
REQ-016 PingResp/PingEnd with valid level 1 -> Check (escalation overrides ping), resp=(1,0).
REQ-017 EscResp: while valid level 1, stay, esc_en_o=1, resp inverts every cycle; valid level 0 -> Idle, esc_en_o=0, resp=(0,1).
REQ-018 Any state with an invalid pair (esc_p_i == esc_n_i) -> SigInt on the next cycle; invalid pair takes priority over every other transition.
REQ-019 SigInt: sigint_o=1, esc_en_o=1, resp_p_o=resp_n_o toggling (1,1),(0,0),... each cycle; valid level 0 -> Idle; valid level 1 -> Check; sigint_o and esc_en_o drop on exit unless the timeout holds esc_en_o.
REQ-020 esc_en_o = (state is EscResp or SigInt) or timeout_o.

Reset
REQ-021 rst_i=1 forces state Idle, resp=(0,1), esc_en_o=0, sigint_o=0, timeout_o=0, timeout counter 0, on the same clk_i edge.
REQ-022 Reset asserted mid-ping or mid-escalation aborts immediately; no partial response pattern resumes after release.
REQ-023 First cycle after reset release samples inputs normally; an invalid pair then enters SigInt per REQ-018.

Configuration
REQ-024 Macro PRIM_ESC_RX_TIMEOUT_EN compiles in the ping-timeout counter.
REQ-025 With the macro: counter width ceil(log2(TimeoutCycles)); increments each cycle in Idle; clears on entering PingEnd, Check, EscResp, or SigInt; at TimeoutCycles-1 it saturates and timeout_o=1 next cycle.
REQ-026 With the macro: timeout_o is sticky until the next PingEnd entry or reset; wrap-around of the counter is forbidden.
REQ-027 Without the macro: no counter is instantiated, timeout_o is tied 0, TimeoutCycles is ignored.

Structure
REQ-028 Package prim_esc_pkg holds the state enum (3-bit, explicit encoding), the Idle response constant (0,1), and the TimeoutCycles minimum constant.
REQ-029 Sub-module prim_diff_decode decodes the esc pair into level and sigint indications; the FSM, response drivers and counter live in prim_esc_receiver.

Verification
REQ-030 Ping: esc=(1,0) one cycle then (0,1) -> resp_p_o=1,0,1,0 over the next four cycles, esc_en_o=0 throughout, then Idle.
REQ-031 Escalation: esc=(1,0) held 10 cycles -> esc_en_o=1 from the third cycle until one cycle after release, resp_p_o alternating, resp_n_o=~resp_p_o.
REQ-032 Integrity: esc=(1,1) 3 cycles then (0,1) -> sigint_o=1 and esc_en_o=1 for 3 cycles, resp pair (1,1),(0,0),(1,1), then resp=(0,1).
REQ-033 Reset mid-escalation: rst_i=1 on cycle 5 of an escalation -> next cycle esc_en_o=0, resp=(0,1), state Idle.
REQ-034 Timeout (macro defined, TimeoutCycles=8): no ping for 8 Idle cycles -> timeout_o=1 and esc_en_o=1; one complete ping -> both clear after PingEnd.
REQ-035 Macro undefined: 1000 Idle cycles -> timeout_o and esc_en_o remain 0.
